apb4_master_bridge: RTL and testbench

Single-outstanding APB4 initiator that converts a valid/ready request/response port into APB4 SETUP/ACCESS transfers. It drives the APB4 bus from the requester side, such as a core load/store unit or a debug module, so that the peripheral slaves in this codebase can be reached. A separate response stage buffers read data and error status until the requester accepts them. An optional watchdog aborts transfers to a slave that never asserts `pready`.

---
 rtl/apb4_if.sv | 31 +++
 rtl/apb4_master_bridge.sv | 147 ++++++++++++++
 tb/tb_apb4_master_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_if.sv
// rtl/apb4_if.sv - APB4 bus signal bundle with master and slave views
//
// Purpose : groups the APB4 request/response wires between one initiator
//           and the slave side so modules can take the bus as one port.
// Ports   : master modport drives paddr/pprot/psel/penable/pwrite/pwdata/pstrb
//           and samples pready/prdata/pslverr; slave modport is the mirror.
interface apb4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// rtl/apb4_master_bridge.sv - single-outstanding valid/ready to APB4 initiator
//
// Purpose : accepts one request at a time, runs an APB4 SETUP/ACCESS transfer
//           and holds the read data / error status until the requester takes it.
// Ports   : pclk, presetn (async active-low)
//           req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i/req_wstrb_i
//           resp_valid_o/resp_ready_i/resp_rdata_o/resp_err_o
//           apb4 (apb4_if.master)
// Options : APB4_MST_TIMEOUT_EN - abort ACCESS after TIMEOUT_CYCLES cycles
//           without pready and return an error response.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  apb4_if.master                  apb4
);

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_dw
    $error("apb4_master_bridge: DATA_WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("apb4_master_bridge: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    tmo_hit;

`ifdef APB4_MST_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Last permitted wait cycle with pready still low: abort instead of waiting.
  assign tmo_hit = (state_q == S_ACCESS) && !apb4.pready &&
                   (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !apb4.pready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus strobes decode straight from the state register, so a reset
  // removes psel/penable immediately rather than at the next edge.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    apb4.psel    = 1'b0;
    apb4.penable = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = S_SETUP;
      end
      S_SETUP: begin
        apb4.psel = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        apb4.psel    = 1'b1;
        apb4.penable = 1'b1;
        if (apb4.pready || tmo_hit) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture; pwdata is only refreshed by writes so reads leave it as-is.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (state_q == S_IDLE && req_valid_i) begin
      paddr_q  <= req_addr_i;
      pwrite_q <= req_write_i;
      pstrb_q  <= req_write_i ? req_wstrb_i : '0;
      if (req_write_i) pwdata_q <= req_wdata_i;
    end
  end

  // Response capture; pready takes priority over a same-cycle timeout.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      if (apb4.pready) begin
        rdata_q <= (!pwrite_q && !apb4.pslverr) ? apb4.prdata : '0;
        err_q   <= apb4.pslverr;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign apb4.paddr   = paddr_q;
  assign apb4.pwrite  = pwrite_q;
  assign apb4.pwdata  = pwdata_q;
  assign apb4.pstrb   = pstrb_q;
  assign apb4.pprot   = 3'b000;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb/tb_apb4_master_bridge.sv - self-checking bench for apb4_master_bridge
module tb_apb4_master_bridge;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_write_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic [SW-1:0] req_wstrb_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;

  always #5 pclk = ~pclk;

  apb4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb4_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .apb4(bus)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            waits;
    logic [DW-1:0] slv_rdata;
    logic          slverr;
    int            resp_delay;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  resp_t         sb[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW-1:0] exp_pwdata;
  vec_t          vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  // At an IDLE negedge: drive the request and queue the expected response.
  task automatic present(input vec_t v);
    resp_t r;
    req_valid_i = 1'b1;
    req_write_i = v.write;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    req_wstrb_i = v.wstrb;
    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    r.rdata = (v.write || v.slverr) ? '0 : v.slv_rdata;
    r.err   = v.slverr;
    sb.push_back(r);
    if (v.write) last_wdata = v.wdata;
    exp_pwdata = last_wdata;
  endtask

  task automatic chk_bus(input vec_t v, input string ph);
    chk({ph, "_paddr"},  64'(bus.paddr),  64'(v.addr));
    chk({ph, "_pwrite"}, 64'(bus.pwrite), 64'(v.write));
    chk({ph, "_pstrb"},  64'(bus.pstrb),  v.write ? 64'(v.wstrb) : 64'd0);
    chk({ph, "_pwdata"}, 64'(bus.pwdata), 64'(exp_pwdata));
    chk({ph, "_pprot"},  64'(bus.pprot),  64'd0);
  endtask

  // From the handshake edge through to the first RESP negedge.
  task automatic setup_access(input vec_t v);
    cyc();
    req_valid_i = 1'b0;
    chk("setup_psel", 64'(bus.psel), 64'd1);
    chk("setup_penable", 64'(bus.penable), 64'd0);
    chk("setup_resp_valid", 64'(resp_valid_o), 64'd0);
    chk_bus(v, "setup");
    for (int w = 0; w <= v.waits; w++) begin
      cyc();
      chk("access_psel", 64'(bus.psel), 64'd1);
      chk("access_penable", 64'(bus.penable), 64'd1);
      chk("access_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("access_req_ready", 64'(req_ready_o), 64'd0);
      chk_bus(v, "access");
      bus.pready  = (w == v.waits);
      bus.prdata  = (w == v.waits) ? v.slv_rdata : $urandom;
      bus.pslverr = (w == v.waits) ? v.slverr : 1'b1;
    end
    cyc();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = $urandom;
    chk("resp_valid", 64'(resp_valid_o), 64'd1);
    chk("resp_psel", 64'(bus.psel), 64'd0);
    chk("resp_penable", 64'(bus.penable), 64'd0);
  endtask

  task automatic finish_resp(input int delay);
    resp_t r;
    for (int i = 0; i < delay; i++) begin
      chk("hold_resp_valid", 64'(resp_valid_o), 64'd1);
      chk("hold_req_ready", 64'(req_ready_o), 64'd0);
      cyc();
    end
    resp_ready_i = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'd1);
    end else begin
      r = sb.pop_front();
      chk("resp_valid_accept", 64'(resp_valid_o), 64'd1);
      chk("resp_rdata", 64'(resp_rdata_o), 64'(r.rdata));
      chk("resp_err", 64'(resp_err_o), 64'(r.err));
    end
    cyc();
    resp_ready_i = 1'b0;
    chk("idle_req_ready", 64'(req_ready_o), 64'd1);
    chk("idle_resp_valid", 64'(resp_valid_o), 64'd0);
  endtask

  initial begin
    vec_t  va, vb, vt;
    resp_t r;
    logic  held;

    //          write  addr          wdata         strb  waits rdata         err delay
    vecs[0] = '{1'b1, 32'h0000_0008, 32'h0000_00A5, 4'hF, 0, 32'h0,         1'b0, 0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 3, 32'hDEAD_BEEF, 1'b0, 0};
    vecs[2] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 32'h1111_1111, 1'b1, 0};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 1, 32'h0,         1'b1, 2};
    vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         4'hC, 2, 32'hCAFE_F00D, 1'b0, 1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 0, 32'h0,         1'b0, 0};

    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;

    #3;
    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_pstrb", 64'(bus.pstrb), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata_o), 64'd0);
    chk("rst_resp_err", 64'(resp_err_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) begin
      present(vecs[i]);
      setup_access(vecs[i]);
      finish_resp(vecs[i].resp_delay);
    end

    // Backpressure with a second request waiting behind the response.
    va = '{1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 32'hA5A5_5A5A, 1'b0, 0};
    vb = '{1'b1, 32'h0000_0034, 32'h0BAD_F00D, 4'h5, 0, 32'h0, 1'b0, 0};
    present(va);
    setup_access(va);
    req_valid_i = 1'b1;
    req_write_i = vb.write;
    req_addr_i  = vb.addr;
    req_wdata_i = vb.wdata;
    req_wstrb_i = vb.wstrb;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 64'(resp_valid_o), 64'd1);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
      chk("bp_rdata", 64'(resp_rdata_o), 64'(32'hA5A5_5A5A));
      chk("bp_psel", 64'(bus.psel), 64'd0);
      cyc();
    end
    resp_ready_i = 1'b1;
    r = sb.pop_front();
    chk("bp_resp_rdata", 64'(resp_rdata_o), 64'(r.rdata));
    chk("bp_resp_err", 64'(resp_err_o), 64'(r.err));
    cyc();
    resp_ready_i = 1'b0;
    chk("bp_idle_psel", 64'(bus.psel), 64'd0);
    present(vb);
    setup_access(vb);
    finish_resp(0);

    // Slave that never raises pready.
    vt = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'h0, 1'b1, 0};
    present(vt);
`ifdef APB4_MST_TIMEOUT_EN
    cyc();
    req_valid_i = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      cyc();
      chk("tmo_access_penable", 64'(bus.penable), 64'd1);
      chk("tmo_access_resp_valid", 64'(resp_valid_o), 64'd0);
    end
    cyc();
    chk("tmo_psel", 64'(bus.psel), 64'd0);
    chk("tmo_resp_valid", 64'(resp_valid_o), 64'd1);
    finish_resp(0);
`else
    void'(sb.pop_back());
    r.rdata = 32'h0000_5555;
    r.err   = 1'b0;
    sb.push_back(r);
    cyc();
    req_valid_i = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (!(bus.psel && bus.penable && !resp_valid_o)) held = 1'b0;
    end
    chk("stuck_access_held", 64'(held), 64'd1);
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_5555;
    cyc();
    bus.pready = 1'b0;
    chk("stuck_resp_valid", 64'(resp_valid_o), 64'd1);
    finish_resp(0);
`endif

    // Asynchronous reset during ACCESS.
    present(vecs[0]);
    cyc();
    req_valid_i = 1'b0;
    cyc();
    chk("prerst_penable", 64'(bus.penable), 64'd1);
    #1;
    presetn = 1'b0;
    #1;
    chk("arst_psel", 64'(bus.psel), 64'd0);
    chk("arst_penable", 64'(bus.penable), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("arst_req_ready", 64'(req_ready_o), 64'd1);
    chk("arst_paddr", 64'(bus.paddr), 64'd0);
    void'(sb.pop_back());
    last_wdata = '0;
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("postrst_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("postrst_req_ready", 64'(req_ready_o), 64'd1);
    end
    present(vecs[1]);
    setup_access(vecs[1]);
    finish_resp(0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
